// File: rtl/updi_seq_pkg.sv
// Shared types for the UPDI instruction sequencer: FSM state encoding,
// instruction status codes and the default SYNCH character.
package updi_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SYNCH    = 3'd1,
        ST_OPCODE   = 3'd2,
        ST_DATA     = 3'd3,
        ST_WAIT_ACK = 3'd4,
        ST_FINISH   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_TIMEOUT = 2'd1,
        ERR_ABORTED = 2'd2
    } err_t;

    localparam logic [7:0] SYNCH_BYTE_DEFAULT = 8'h55;

endpackage

// File: rtl/updi_ack_timer.sv
// ACK wait timer: counts enabled cycles after a clear and flags the cycle in
// which the count sits at TERMINAL-1. Only built when UPDI_ACK_TIMEOUT_EN is set.
module updi_ack_timer #(
    parameter int TERMINAL = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TERMINAL) + 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(TERMINAL - 1);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

    logic [CW-1:0] count_r;

    // Cycle counter: cleared outside the wait, saturates at the terminal count
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_r <= {CW{1'b0}};
        end else if (clear) begin
            count_r <= {CW{1'b0}};
        end else if (enable && (count_r != LAST_COUNT)) begin
            count_r <= count_r + COUNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = enable && (count_r == LAST_COUNT);

endmodule

// File: rtl/updi_instruction_sequencer.sv
// UPDI instruction sequencer: pushes optional SYNCH, opcode and payload bytes
// into the PHY TX FIFO, stalling on FIFO full and on per-byte ACK requests.
// Supports abort, a done pulse and a status code for the last instruction.
// Optional build macro UPDI_ACK_TIMEOUT_EN enables the ACK wait timeout.
module updi_instruction_sequencer
    import updi_seq_pkg::*;
#(
    parameter int         MAX_DATA_SIZE      = 16,
    parameter int         DATA_ADDR_BITS     = $clog2(MAX_DATA_SIZE),
    parameter logic [7:0] SYNCH_BYTE         = SYNCH_BYTE_DEFAULT,
    parameter int         ACK_TIMEOUT_CYCLES = 4096
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          send_synch,
    input  logic [7:0]                    opcode,
    input  logic [MAX_DATA_SIZE-1:0][7:0] data,
    input  logic [DATA_ADDR_BITS:0]       data_len,
    input  logic [MAX_DATA_SIZE-1:0]      wait_ack_after,
    input  logic                          abort,
    input  logic                          ack_received,
    output logic                          ready,
    output logic                          waiting_for_ack,
    output logic                          done,
    output logic [1:0]                    error_code,
    output logic [7:0]                    fifo_data,
    output logic                          fifo_wr_en,
    input  logic                          fifo_full
);

    localparam int LEN_W = DATA_ADDR_BITS + 1;
    localparam logic [LEN_W-1:0]          MAX_LEN = LEN_W'(MAX_DATA_SIZE);
    localparam logic [LEN_W-1:0]          LEN_ONE = LEN_W'(1);
    localparam logic [DATA_ADDR_BITS-1:0] IDX_ONE = DATA_ADDR_BITS'(1);

    state_t                          state_r;
    state_t                          state_nxt_s;
    err_t                            err_r;
    err_t                            err_nxt_s;
    logic [7:0]                      opcode_r;
    logic [MAX_DATA_SIZE-1:0][7:0]   data_r;
    logic [MAX_DATA_SIZE-1:0]        wait_ack_r;
    logic [LEN_W-1:0]                len_r;
    logic [LEN_W-1:0]                len_clamped_s;
    logic [DATA_ADDR_BITS-1:0]       idx_r;
    logic                            ready_r;
    logic                            waiting_r;
    logic                            done_r;
    logic                            abort_s;
    logic                            write_s;
    logic                            last_s;
    logic                            inc_idx_s;
    logic                            expired_s;

`ifdef UPDI_ACK_TIMEOUT_EN
    updi_ack_timer #(
        .TERMINAL (ACK_TIMEOUT_CYCLES)
    ) u_ack_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_r != ST_WAIT_ACK),
        .enable  (state_r == ST_WAIT_ACK),
        .expired (expired_s)
    );
`else
    // Without the timer the wait never expires; the parameter stays for a
    // uniform interface across builds.
    assign expired_s = (ACK_TIMEOUT_CYCLES < 32'sd0);
`endif

    // Per-cycle qualifiers: abort reach, byte write, last-byte and length clamp.
    // FINISH already completes the instruction, so abort there has no effect.
    always_comb begin
        abort_s       = abort && (state_r inside {ST_SYNCH, ST_OPCODE, ST_DATA, ST_WAIT_ACK});
        write_s       = rst && !fifo_full && !abort
                        && (state_r inside {ST_SYNCH, ST_OPCODE, ST_DATA});
        last_s        = (({1'b0, idx_r}) + LEN_ONE) == len_r;
        len_clamped_s = (data_len > MAX_LEN) ? MAX_LEN : data_len;
    end

    // Byte presented to the TX FIFO in the write states
    always_comb begin
        fifo_data = 8'h00;
        case (state_r)
            ST_SYNCH:  fifo_data = SYNCH_BYTE;
            ST_OPCODE: fifo_data = opcode_r;
            ST_DATA:   fifo_data = data_r[idx_r];
            default:   fifo_data = 8'h00;
        endcase
    end

    // Next state, next status and payload-index advance
    always_comb begin
        state_nxt_s = state_r;
        err_nxt_s   = err_r;
        inc_idx_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = send_synch ? ST_SYNCH : ST_OPCODE;
                    err_nxt_s   = ERR_NONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SYNCH: begin
                if (abort_s) begin
                    state_nxt_s = ST_FINISH;
                    err_nxt_s   = ERR_ABORTED;
                end else if (write_s) begin
                    state_nxt_s = ST_OPCODE;
                end else begin
                    state_nxt_s = ST_SYNCH;
                end
            end
            ST_OPCODE: begin
                if (abort_s) begin
                    state_nxt_s = ST_FINISH;
                    err_nxt_s   = ERR_ABORTED;
                end else if (write_s) begin
                    state_nxt_s = (len_r != {LEN_W{1'b0}}) ? ST_DATA : ST_FINISH;
                end else begin
                    state_nxt_s = ST_OPCODE;
                end
            end
            ST_DATA: begin
                if (abort_s) begin
                    state_nxt_s = ST_FINISH;
                    err_nxt_s   = ERR_ABORTED;
                end else if (write_s) begin
                    if (wait_ack_r[idx_r]) begin
                        state_nxt_s = ST_WAIT_ACK;
                    end else if (last_s) begin
                        state_nxt_s = ST_FINISH;
                    end else begin
                        state_nxt_s = ST_DATA;
                        inc_idx_s   = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_WAIT_ACK: begin
                if (abort_s) begin
                    state_nxt_s = ST_FINISH;
                    err_nxt_s   = ERR_ABORTED;
                end else if (ack_received) begin
                    if (last_s) begin
                        state_nxt_s = ST_FINISH;
                    end else begin
                        state_nxt_s = ST_DATA;
                        inc_idx_s   = 1'b1;
                    end
                end else if (expired_s) begin
                    state_nxt_s = ST_FINISH;
                    err_nxt_s   = ERR_TIMEOUT;
                end else begin
                    state_nxt_s = ST_WAIT_ACK;
                end
            end
            ST_FINISH: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, latched instruction and registered status outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            err_r      <= ERR_NONE;
            idx_r      <= {DATA_ADDR_BITS{1'b0}};
            ready_r    <= 1'b1;
            waiting_r  <= 1'b0;
            done_r     <= 1'b0;
            opcode_r   <= 8'h00;
            data_r     <= {(MAX_DATA_SIZE*8){1'b0}};
            wait_ack_r <= {MAX_DATA_SIZE{1'b0}};
            len_r      <= {LEN_W{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            err_r     <= err_nxt_s;
            ready_r   <= (state_nxt_s == ST_IDLE);
            waiting_r <= (state_nxt_s == ST_WAIT_ACK);
            done_r    <= (state_nxt_s == ST_FINISH);
            if ((state_r == ST_IDLE) && start) begin
                opcode_r   <= opcode;
                data_r     <= data;
                wait_ack_r <= wait_ack_after;
                len_r      <= len_clamped_s;
                idx_r      <= {DATA_ADDR_BITS{1'b0}};
            end else if (inc_idx_s) begin
                idx_r <= idx_r + IDX_ONE;
            end else begin
                idx_r <= idx_r;
            end
        end
    end

    assign ready           = ready_r;
    assign waiting_for_ack = waiting_r;
    assign done            = done_r;
    assign error_code      = err_r;
    assign fifo_wr_en      = write_s;

endmodule

// File: tb/tb_updi_instruction_sequencer.sv
// Self-checking bench for updi_instruction_sequencer: directed scenarios with
// literal expectations plus randomized traffic checked every cycle against a
// queue-based model of the byte stream. Honours UPDI_ACK_TIMEOUT_EN.
module tb_updi_instruction_sequencer;

    localparam int MDS    = 16;
    localparam int AW     = 4;
    localparam int TO_CYC = 8;
`ifdef UPDI_ACK_TIMEOUT_EN
    localparam int HOLD = 6;
`else
    localparam int HOLD = 10;
`endif

    logic                clk = 1'b0;
    logic                rst, start, send_synch, abort, ack_received, fifo_full;
    logic [7:0]          opcode;
    logic [MDS-1:0][7:0] data;
    logic [AW:0]         data_len;
    logic [MDS-1:0]      wait_ack_after;
    logic                ready, waiting_for_ack, done, fifo_wr_en;
    logic [1:0]          error_code;
    logic [7:0]          fifo_data;

    int checks = 0;
    int errors = 0;

    // Environment: TX FIFO occupancy and log of bytes written
    int         fifo_cnt   = 0;
    int         fifo_depth = 16;
    bit         rand_mode  = 1'b0;
    logic [7:0] tx_log[$];
    int         done_seen  = 0;

    // Model: remaining bytes of the instruction and their ACK-after flags
    bit         m_valid = 1'b0, m_busy = 1'b0, m_waiting = 1'b0, m_finishing = 1'b0;
    int         m_err = 0, m_wait_cnt = 0;
    logic [7:0] m_bytes[$];
    bit         m_ackq[$];
    logic       exp_wr;

    updi_instruction_sequencer #(
        .MAX_DATA_SIZE      (MDS),
        .ACK_TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk (clk), .rst (rst), .start (start), .send_synch (send_synch),
        .opcode (opcode), .data (data), .data_len (data_len),
        .wait_ack_after (wait_ack_after), .abort (abort),
        .ack_received (ack_received), .ready (ready),
        .waiting_for_ack (waiting_for_ack), .done (done),
        .error_code (error_code), .fifo_data (fifo_data),
        .fifo_wr_en (fifo_wr_en), .fifo_full (fifo_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] log_at(input int i);
        if (i < tx_log.size()) return tx_log[i];
        else return 8'hxx;
    endfunction

    // Advance the model across the coming clock edge using the current inputs
    task automatic model_step();
        int n;
        bit a;
        if (!rst) begin
            m_valid = 1'b1; m_busy = 1'b0; m_waiting = 1'b0; m_finishing = 1'b0;
            m_err = 0; m_bytes.delete(); m_ackq.delete();
        end else if (!m_valid) begin
            m_valid = 1'b0;
        end else if (m_finishing) begin
            m_finishing = 1'b0;
        end else if (!m_busy) begin
            if (start) begin
                m_bytes.delete(); m_ackq.delete(); m_err = 0;
                if (send_synch) begin m_bytes.push_back(8'h55); m_ackq.push_back(1'b0); end
                m_bytes.push_back(opcode); m_ackq.push_back(1'b0);
                n = (int'(data_len) > MDS) ? MDS : int'(data_len);
                for (int i = 0; i < n; i++) begin
                    m_bytes.push_back(data[i]); m_ackq.push_back(wait_ack_after[i]);
                end
                m_busy = 1'b1; m_waiting = 1'b0;
            end
        end else if (abort) begin
            m_bytes.delete(); m_ackq.delete();
            m_busy = 1'b0; m_waiting = 1'b0; m_finishing = 1'b1; m_err = 2;
        end else if (m_waiting) begin
            if (ack_received) begin
                m_waiting = 1'b0;
                if (m_bytes.size() == 0) begin m_busy = 1'b0; m_finishing = 1'b1; end
            end
`ifdef UPDI_ACK_TIMEOUT_EN
            else if (m_wait_cnt == TO_CYC - 1) begin
                m_bytes.delete(); m_ackq.delete();
                m_busy = 1'b0; m_waiting = 1'b0; m_finishing = 1'b1; m_err = 1;
            end
`endif
            else begin
                m_wait_cnt++;
            end
        end else if (!fifo_full) begin
            a = m_ackq.pop_front();
            void'(m_bytes.pop_front());
            if (a) begin
                m_waiting = 1'b1; m_wait_cnt = 0;
            end else if (m_bytes.size() == 0) begin
                m_busy = 1'b0; m_finishing = 1'b1;
            end
        end
    endtask

    // Compare DUT outputs with the model mid-cycle, then advance the model
    always @(negedge clk) begin
        if (m_valid) begin
            exp_wr = rst && m_busy && !m_waiting && !fifo_full && !abort;
            check("ready", ready, !m_busy && !m_finishing);
            check("waiting_for_ack", waiting_for_ack, m_waiting);
            check("done", done, m_finishing);
            check("error_code", error_code, m_err);
            check("fifo_wr_en", fifo_wr_en, exp_wr);
            if (exp_wr) check("fifo_data", fifo_data, m_bytes[0]);
        end
        if (done === 1'b1) done_seen++;
        model_step();
    end

    // One clock: record the write seen before the edge, update FIFO level after it
    task automatic tick();
        logic       w;
        logic [7:0] d;
        @(negedge clk);
        w = fifo_wr_en;
        d = fifo_data;
        @(posedge clk);
        #1;
        if (w === 1'b1) begin tx_log.push_back(d); fifo_cnt++; end
        if (rand_mode) fifo_full = ($urandom_range(0, 2) == 0);
        else fifo_full = (fifo_cnt >= fifo_depth);
    endtask

    task automatic set_level(input int n);
        fifo_cnt  = n;
        fifo_full = (fifo_cnt >= fifo_depth);
    endtask

    task automatic run_until_idle(input int budget);
        int k;
        k = 0;
        while ((ready !== 1'b1) && (k < budget)) begin tick(); k++; end
        check("idle_within_budget", ready, 1);
    endtask

    task automatic begin_test(input int depth);
        tx_log.delete(); done_seen = 0; fifo_depth = depth; set_level(0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; send_synch = 1'b0; opcode = 8'h00;
        data = '0; data_len = '0; wait_ack_after = '0; abort = 1'b0;
        ack_received = 1'b0; fifo_full = 1'b0;
        tick(); tick();
        rst = 1'b1;
        check("rst_ready", ready, 1);
        check("rst_waiting", waiting_for_ack, 0);
        check("rst_done", done, 0);
        check("rst_error", error_code, 0);

        // SYNCH + opcode, no payload
        begin_test(16);
        start = 1'b1; send_synch = 1'b1; opcode = 8'hE5; data_len = 5'd0;
        tick(); start = 1'b0;
        check("t1_busy", ready, 0);
        tick(); tick();
        check("t1_done", done, 1);
        tick();
        check("t1_ready", ready, 1);
        check("t1_done_clear", done, 0);
        check("t1_error", error_code, 0);
        check("t1_count", tx_log.size(), 2);
        check("t1_b0", log_at(0), 8'h55);
        check("t1_b1", log_at(1), 8'hE5);
        check("t1_done_pulses", done_seen, 1);

        // Opcode + two bytes, no ACK
        begin_test(16);
        start = 1'b1; send_synch = 1'b0; opcode = 8'h45;
        data[0] = 8'h12; data[1] = 8'h34; data_len = 5'd2; wait_ack_after = 16'h0000;
        tick(); start = 1'b0;
        run_until_idle(10);
        check("t2_count", tx_log.size(), 3);
        check("t2_b0", log_at(0), 8'h45);
        check("t2_b1", log_at(1), 8'h12);
        check("t2_b2", log_at(2), 8'h34);

        // Depth-4 FIFO with ACK after payload bytes 1 and 3
        begin_test(4);
        start = 1'b1; send_synch = 1'b1; opcode = 8'h45;
        data[0] = 8'h12; data[1] = 8'h34; data[2] = 8'h56; data[3] = 8'h78;
        data_len = 5'd4; wait_ack_after = 16'b1010;
        tick(); start = 1'b0;
        repeat (4) tick();
        for (int k = 0; k < HOLD; k++) begin
            check("t3_hold_wait", waiting_for_ack, 1);
            tick();
        end
        check("t3_stall_count", tx_log.size(), 4);
        check("t3_b3", log_at(3), 8'h34);
        set_level(0);
        ack_received = 1'b1; tick(); ack_received = 1'b0;
        tick(); tick();
        check("t3_wait2", waiting_for_ack, 1);
        check("t3_not_ready", ready, 0);
        check("t3_b4", log_at(4), 8'h56);
        check("t3_b5", log_at(5), 8'h78);
        ack_received = 1'b1; tick(); ack_received = 1'b0;
        check("t3_done", done, 1);
        tick();
        check("t3_ready", ready, 1);

        // Abort while stalled on full; abort wins over a write that just became possible
        begin_test(2);
        start = 1'b1; send_synch = 1'b0; opcode = 8'h45;
        data[0] = 8'h12; data[1] = 8'h34; data[2] = 8'h56; data_len = 5'd3;
        wait_ack_after = 16'h0000;
        tick(); start = 1'b0;
        repeat (4) tick();
        check("t4_stalled_count", tx_log.size(), 2);
        set_level(0); abort = 1'b1;
        #1;
        check("t4_abort_no_write", fifo_wr_en, 0);
        tick(); abort = 1'b0;
        check("t4_done", done, 1);
        check("t4_error", error_code, 2);
        tick();
        check("t4_error_held", error_code, 2);
        check("t4_count", tx_log.size(), 2);
        start = 1'b1; abort = 1'b1; opcode = 8'h11; data_len = 5'd0;
        tick(); start = 1'b0; abort = 1'b0;
        check("t4_error_cleared", error_code, 0);
        check("t4_start_wins", ready, 0);
        run_until_idle(10);

`ifdef UPDI_ACK_TIMEOUT_EN
        // ACK timeout after payload byte 0
        begin_test(16);
        start = 1'b1; send_synch = 1'b0; opcode = 8'h66;
        data[0] = 8'hAA; data[1] = 8'hBB; data_len = 5'd2; wait_ack_after = 16'h0001;
        tick(); start = 1'b0;
        tick(); tick();
        repeat (7) tick();
        check("t5_still_waiting", waiting_for_ack, 1);
        tick();
        check("t5_done", done, 1);
        check("t5_timeout", error_code, 1);
        tick();
        check("t5_count", tx_log.size(), 2);
        // ACK on the last allowed cycle beats the timeout
        begin_test(16);
        start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        repeat (7) tick();
        ack_received = 1'b1; tick(); ack_received = 1'b0;
        check("t5b_no_timeout", done, 0);
        run_until_idle(10);
        check("t5b_error", error_code, 0);
        check("t5b_last", log_at(2), 8'hBB);
`endif

        // Reset in WAIT_ACK, then reset in DATA with FIFO space
        begin_test(16);
        start = 1'b1; send_synch = 1'b0; opcode = 8'h77;
        data_len = 5'd1; wait_ack_after = 16'h0001;
        tick(); start = 1'b0;
        tick(); tick();
        check("t6_in_wait", waiting_for_ack, 1);
        rst = 1'b0; #1;
        check("t6_wr_in_reset_a", fifo_wr_en, 0);
        tick(); rst = 1'b1;
        check("t6_ready_a", ready, 1);
        check("t6_wait_a", waiting_for_ack, 0);
        start = 1'b1; data_len = 5'd3; wait_ack_after = 16'h0000;
        tick(); start = 1'b0;
        tick();
        rst = 1'b0; #1;
        check("t6_wr_in_reset_b", fifo_wr_en, 0);
        tick(); rst = 1'b1;
        check("t6_ready_b", ready, 1);
        check("t6_wait_b", waiting_for_ack, 0);
        check("t6_done_b", done, 0);

        // Randomized traffic against the model
        rand_mode = 1'b1;
        repeat (3000) begin
            start          = ($urandom_range(0, 3) == 0);
            send_synch     = 1'($urandom_range(0, 1));
            opcode         = 8'($urandom);
            for (int i = 0; i < MDS; i++) data[i] = 8'($urandom);
            data_len       = 5'($urandom_range(0, 20));
            wait_ack_after = 16'($urandom & $urandom & $urandom);
            abort          = ($urandom_range(0, 24) == 0) && !m_finishing;
            ack_received   = ($urandom_range(0, 3) == 0);
            rst            = !($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b1; abort = 1'b0; start = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/updi_instruction_sequencer.md
Name: updi_instruction_sequencer

Overview:
Next-generation UPDI instruction front end. Takes one instruction (opcode plus up to MAX_DATA_SIZE payload bytes) and pushes SYNCH (optional), opcode and payload into the PHY TX FIFO, honouring FIFO backpressure. It stalls for a target ACK after any flagged byte. Compared with the previous handler it adds per-instruction SYNCH suppression, abort, ACK timeout, a completion pulse and an error code. It sits between the UPDI command controller and the TX byte FIFO.

Parameters:
MAX_DATA_SIZE, 16, maximum payload bytes per instruction
DATA_ADDR_BITS, $clog2(MAX_DATA_SIZE), payload index width
SYNCH_BYTE, 8'h55, value written as the SYNCH character
ACK_TIMEOUT_CYCLES, 4096, clock cycles allowed in WAIT_ACK before timeout (effective only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
start  in  1  accept instruction when ready=1
send_synch  in  1  prepend SYNCH_BYTE, sampled with start
opcode  in  8  instruction opcode
data  in  8 x MAX_DATA_SIZE  payload, data[0] is sent first
data_len  in  DATA_ADDR_BITS+1  payload byte count
wait_ack_after  in  MAX_DATA_SIZE  bit i=1: wait for ACK after data[i]
abort  in  1  cancel the current instruction
ack_received  in  1  ACK seen by the RX path
ready  out  1  idle and able to accept start
waiting_for_ack  out  1  in WAIT_ACK
done  out  1  one-cycle pulse at the end of every instruction
error_code  out  2  status of the last instruction
fifo_data  out  8  byte to TX FIFO
fifo_wr_en  out  1  write strobe to TX FIFO
fifo_full  in  1  TX FIFO full

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE, ready=1, waiting_for_ack=0, done=0, error_code=NONE, byte index 0. fifo_wr_en is forced 0 during any cycle with rst=0.
- States: IDLE, SYNCH, OPCODE, DATA, WAIT_ACK, FINISH.
- IDLE: ready=1. On start=1, latch all instruction inputs, clear error_code, then go to SYNCH if send_synch=1, else OPCODE. start when not ready is ignored.
- data_len above MAX_DATA_SIZE is clamped to MAX_DATA_SIZE at latch.
- Write states (SYNCH, OPCODE, DATA):
  - fifo_wr_en = !fifo_full, combinational. fifo_data is SYNCH_BYTE, opcode or data[idx].
  - State advances only on a cycle in which the write occurs. Full FIFO stalls indefinitely with no byte lost or duplicated.
  - One byte per cycle maximum.
- Transitions after a write:
  - SYNCH -> OPCODE.
  - OPCODE -> DATA if len>0, else FINISH.
  - DATA[idx] -> WAIT_ACK if wait_ack_after[idx]. Otherwise DATA[idx+1], or FINISH when idx=len-1.
- WAIT_ACK: waiting_for_ack=1. On ack_received=1, resume DATA[idx+1], or FINISH if it was the last byte.
  - ack_received outside WAIT_ACK is ignored.
  - wait_ack_after bits at or beyond len are ignored.
- FINISH: done=1 for one cycle, then IDLE. ready returns the following cycle.
- Abort:
  - abort=1 in any non-IDLE state -> FINISH next edge, with error_code=ABORTED.
  - No FIFO write occurs in the abort cycle; abort has priority over a pending write.
  - abort in IDLE is ignored.
- error_code values: NONE=0, TIMEOUT=1, ABORTED=2. Held until the next accepted start.
- Simultaneous start and abort in IDLE: start accepted, abort ignored.

Optional Feature:
UPDI_ACK_TIMEOUT_EN
- Defined: a cycle counter clears on WAIT_ACK entry and increments each WAIT_ACK cycle. When it reaches ACK_TIMEOUT_CYCLES-1 without ACK, go to FINISH with error_code=TIMEOUT; the remaining bytes are dropped. ack_received in that same cycle wins (no timeout).
- Undefined: WAIT_ACK waits forever, and TIMEOUT is never reported.

Decomposition:
- Package updi_seq_pkg holds: state enum, error_code enum (NONE/TIMEOUT/ABORTED), SYNCH_BYTE default constant.
- Sub-module updi_ack_timer: a clear/enable counter asserting expired at terminal count, instantiated only under UPDI_ACK_TIMEOUT_EN.

Test Plan:
1. send_synch=1, opcode=8'hE5, len=0, FIFO drained -> FIFO holds 55,E5; done pulses once; error_code=0; ready after 4 cycles.
2. send_synch=0, opcode=8'h45, data=12,34, len=2, no ACK -> FIFO holds 45,12,34 only.
3. Depth-4 FIFO, SYNCH on, opcode 45, data 12,34,56,78, ACK after bytes 1 and 3:
   - Stall with 55,45,12,34 written; waiting_for_ack=1 held 10 cycles.
   - Ack -> 56,78 written; second WAIT_ACK, ready=0.
   - Second ack -> done pulse, ready=1.
4. Abort asserted while stalled on fifo_full mid-payload -> no further FIFO writes; done pulses; error_code=2; next start clears error_code to 0.
5. UPDI_ACK_TIMEOUT_EN defined, ACK_TIMEOUT_CYCLES=8, ACK after byte 0, no ack -> 8 cycles after WAIT_ACK entry, done with error_code=1 and no later bytes written. Repeat with ack on cycle 8 -> no timeout.
6. rst=0 asserted in WAIT_ACK and in DATA with FIFO space -> next cycle ready=1, waiting_for_ack=0, fifo_wr_en=0 during reset.
